// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: requester fields, responses and the shared data-memory port of dm_arbiter.
interface dm_arbiter_if;
  logic [1:0] reqValid;
  logic [31:0] reqAddress0, reqAddress1;
  logic [2:0] reqReadType0, reqReadType1;
  logic [1:0] reqWriteType0, reqWriteType1;
  logic [31:0] reqWriteInput0, reqWriteInput1;
  logic [1:0] ack;
  logic [31:0] respData;
  logic respError;
  logic [31:0] dmAddress;
  logic [2:0] dmReadType;
  logic [1:0] dmWriteType;
  logic [31:0] dmWriteInput;
  logic [31:0] dmReadResult;
  modport slave (
    input reqValid, reqAddress0, reqAddress1, reqReadType0, reqReadType1,
    input reqWriteType0, reqWriteType1, reqWriteInput0, reqWriteInput1, dmReadResult,
    output ack, respData, respError, dmAddress, dmReadType, dmWriteType, dmWriteInput
  );
  modport master (
    output reqValid, reqAddress0, reqAddress1, reqReadType0, reqReadType1,
    output reqWriteType0, reqWriteType1, reqWriteInput0, reqWriteInput1, dmReadResult,
    input ack, respData, respError, dmAddress, dmReadType, dmWriteType, dmWriteInput
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: alternating-priority arbiter of two requesters onto one data-memory port, ack one cycle later.
// Define DM_ARBITER_ALIGN_CHECK_EN to block misaligned stores and flag them on respError.
module dm_arbiter #(
  parameter int PRIO_INIT = 0
) (
  input logic clock,
  input logic reset,
  dm_arbiter_if.slave bus
);
  typedef enum logic {IDLE, RESP} state_e;
  state_e state_q, state_d;
  logic prio_q, prio_d, win_q, win_d, err_q, err_d;
  logic [31:0] data_q, data_d;
  logic any_req, win, mis;
  logic [31:0] addr;
  logic [2:0] rt;
  logic [1:0] wt;
  assign any_req = |bus.reqValid;
  assign win = &bus.reqValid ? prio_q : bus.reqValid[1];
  assign addr = win ? bus.reqAddress1 : bus.reqAddress0;
  assign rt = win ? bus.reqReadType1 : bus.reqReadType0;
  assign wt = win ? bus.reqWriteType1 : bus.reqWriteType0;
`ifdef DM_ARBITER_ALIGN_CHECK_EN
  logic [1:0] sz;
  // loads follow RISC-V funct3 widths: [1:0]=01 half, 10 word, else byte
  assign sz = wt != 2'b00 ? wt : rt[1:0] == 2'b01 ? 2'b10 : rt[1:0] == 2'b10 ? 2'b11 : 2'b01;
  assign mis = (sz == 2'b10 && addr[0]) || (sz == 2'b11 && addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  always_comb begin
    state_d = IDLE;
    prio_d = prio_q;
    win_d = win_q;
    err_d = err_q;
    data_d = data_q;
    bus.dmAddress = '0;
    bus.dmReadType = '0;
    bus.dmWriteType = '0;
    bus.dmWriteInput = '0;
    if (state_q == IDLE && any_req) begin
      state_d = RESP;
      prio_d = ~win;
      win_d = win;
      err_d = mis;
      data_d = bus.dmReadResult;
      bus.dmAddress = addr;
      bus.dmReadType = rt;
      bus.dmWriteType = mis ? 2'b00 : wt;
      bus.dmWriteInput = win ? bus.reqWriteInput1 : bus.reqWriteInput0;
    end
  end
  always_ff @(posedge clock)
    if (reset) begin
      state_q <= IDLE;
      prio_q <= 1'(PRIO_INIT);
      win_q <= 1'b0;
      err_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      win_q <= win_d;
      err_q <= err_d;
      data_q <= data_d;
    end
  // reset in the ack cycle cancels that ack
  assign bus.ack = (state_q == RESP && !reset) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.respData = data_q;
`ifdef DM_ARBITER_ALIGN_CHECK_EN
  assign bus.respError = err_q;
`else
  assign bus.respError = 1'b0;
`endif
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter PRIO_INIT, default 0: requester index (0 or 1) that holds priority after reset.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqValid[1:0]  input  2  per-requester request; held high with its fields stable until that requester's ack.
REQ-005 reqAddress0/reqAddress1  input  32  byte address per requester.
REQ-006 reqReadType0/reqReadType1  input  3  load type per requester, passed through to memory unchanged.
REQ-007 reqWriteType0/reqWriteType1  input  2  store type per requester: 00 none, 01 byte, 10 half, 11 word.
REQ-008 reqWriteInput0/reqWriteInput1  input  32  store data per requester.
REQ-009 ack[1:0]  output  2  one-cycle completion pulse per requester.
REQ-010 respData  output  32  registered load result, valid only in the ack cycle.
REQ-011 respError  output  1  misalignment flag, valid only in the ack cycle.
REQ-012 dmAddress/dmReadType/dmWriteType/dmWriteInput  output  32/3/2/32  shared data-memory port.
REQ-013 dmReadResult  input  32  combinational read data from the data memory.

Function
REQ-014 FSM states: IDLE and RESP.
REQ-015 IDLE with no reqValid bit set: memory port idle (dmWriteType 00, others 0), stay IDLE.
REQ-016 IDLE with exactly one reqValid bit set: that requester wins.
REQ-017 IDLE with both bits set: the priority holder wins, and priority then passes to the loser.
REQ-018 Single-requester win: priority passes to the other requester.
REQ-019 Win cycle, part 1: winner's fields drive the memory port combinationally in the same cycle.
REQ-020 Win cycle, part 2: dmReadResult is captured into respData; winner index and error flag are registered; next state is RESP.
REQ-021 Stores commit at the memory on the rising edge that ends the win cycle.
REQ-022 RESP: ack[winner] = 1 for exactly one cycle, respData and respError valid, memory port idle; next state IDLE.
REQ-023 Fixed latency: request sampled in cycle N gives ack in cycle N+1.
REQ-024 Throughput: at most one access per two cycles.
REQ-025 A requester acked in cycle N+1 and still requesting in N+2 is a new request.
REQ-026 Input changes during RESP are ignored; arbitration happens only in IDLE.
REQ-027 ack bits are mutually exclusive and never asserted in IDLE.
REQ-028 For a store, respData holds the pre-write word read in the win cycle; requesters ignore it.
REQ-029 The arbiter never modifies address, data or type fields, only selects them.

Reset
REQ-030 Reset forces state IDLE, priority PRIO_INIT, ack 0, respData 0, respError 0 and a zeroed memory port.
REQ-031 Reset asserted in the win cycle suppresses the pending ack, but the memory write on that edge occurs.
REQ-032 Reset asserted in RESP suppresses that ack.

Configuration
REQ-033 Macro DM_ARBITER_ALIGN_CHECK_EN enables the misalignment check.
REQ-034 Defined, misaligned cases: half with address bit0=1, or word with address[1:0]≠00 (read or write).
REQ-035 Defined, misaligned response: dmWriteType is forced to 00 in the win cycle and respError is 1 in the ack cycle.
REQ-036 Defined, other behaviour: arbitration, latency and ack are unchanged.
REQ-037 Undefined: no check logic; respError is tied to 0; all accesses pass through.

Verification
REQ-038 Reset, then only req0 loads word at 0x10 holding 0x12345678 -> ack=01 one cycle later, respData=0x12345678, respError=0.
REQ-039 Both requesters request in the same cycle, PRIO_INIT=0 -> req0 acked at N+1, req1 wins at N+2 and is acked at N+3.
REQ-040 req1 stores byte 0xAB at 0x21 over 0x00000000, then req1 loads word at 0x20 -> respData=0x0000AB00.
REQ-041 Both requesters hold requests for 8 cycles -> acks alternate 01,10,01,10 with one idle cycle between each.
REQ-042 With DM_ARBITER_ALIGN_CHECK_EN, req0 stores word at 0x22 -> respError=1 and memory unchanged; without the macro, respError=0 and the word is written.
REQ-043 Reset asserted in a RESP cycle -> ack stays 00, next cycle is IDLE with priority PRIO_INIT.
